// File: rtl/axi_stream_pattern_source_pkg.sv
// Shared types for the test-pattern stream source: pixel width, pattern codes, FSM states.
// Latency: n/a (types and pure helper function only).
// Backpressure: n/a.
package pattern_src_pkg;

    localparam int PIXEL_W = 24;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        PAT_SOLID   = 2'd0,
        PAT_HRAMP   = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_BARS    = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_e;

    // Expand a 3-bit {R,G,B} selector into a full-intensity-or-off 24-bit colour.
    function automatic pixel_t rgb_from_bits(input logic [2:0] b);
        return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    endfunction

endpackage

// File: rtl/axi_stream_pattern_source_if.sv
// AXI-Stream video beat bundle: 24-bit RGB pixel plus valid/ready, tlast (EOF) and tuser (SOF).
// Latency: n/a (wires only).
// Backpressure: ready flows slave->master; master holds the beat while valid && !ready.
interface axi_stream_pattern_source_if;
    import pattern_src_pkg::*;

    pixel_t tdata;
    logic   tvalid;
    logic   tlast;
    logic   tuser;
    logic   tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/axi_stream_pattern_source_pixel_gen.sv
// Colour for one pixel position of the selected test pattern.
// Latency: combinational (0 cycles).
// Backpressure: none; caller decides when the result is registered.
module pattern_pixel_gen
    import pattern_src_pkg::*;
#(
    parameter int LINE_PIXELS = 480
) (
    input  pattern_e    pattern,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output pixel_t      pixel
);

    // Colour-bar index: eight equal-width bars across the line, clipped so rounding can never yield bar 8.
    logic [18:0] x_times8;
    logic [18:0] bar_raw;
    logic [2:0]  bar;
    // Checkerboard only needs bit 3 of the line index (8x8 squares).
    logic        unused_y;

    assign x_times8 = {x, 3'b000};
    assign bar_raw  = x_times8 / 19'(LINE_PIXELS);
    assign bar      = (bar_raw > 19'd7) ? 3'd7 : bar_raw[2:0];
    assign unused_y = ^{y[15:4], y[2:0]};

    // Pattern decode; anything unexpected produces black.
    always_comb begin
        pixel = '0;
        case (pattern)
            PAT_SOLID:   pixel = 24'hFFFFFF;
            PAT_HRAMP:   pixel = {3{x[7:0]}};
            PAT_CHECKER: pixel = (x[3] ^ y[3]) ? 24'hFFFFFF : 24'h000000;
            PAT_BARS:    pixel = rgb_from_bits(bar);
            default:     pixel = '0;
        endcase
    end

endmodule

// File: rtl/axi_stream_pattern_source.sv
// Frame-based AXI-Stream test-pattern generator (SOLID/HRAMP/CHECKER/BARS) with inter-frame idle gap.
// Latency: first beat 2 cycles after enable is sampled high; pixel registered alongside its beat position.
// Backpressure: beat, tlast and tuser held stable while tvalid && !tready; counters advance only on accept.
// Optional: define PATTERN_SRC_FRAME_XOR_EN to add frame_xor, the XOR of all beats of the last completed frame.
module axi_stream_pattern_source
    import pattern_src_pkg::*;
#(
    parameter int LINE_PIXELS = 480,
    parameter int FRAME_LINES = 272,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic [1:0]                         pattern_sel,
    axi_stream_pattern_source_if.master        m_axis,
    output logic [31:0]                        frame_count,
    output logic                               busy
`ifdef PATTERN_SRC_FRAME_XOR_EN
    ,
    output logic [31:0]                        frame_xor
`endif
);

    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [15:0]      X_LAST  = 16'(LINE_PIXELS - 1);
    localparam logic [15:0]      Y_LAST  = 16'(FRAME_LINES - 1);
    localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_LAST);

    state_e           state_q, state_d;
    logic [15:0]      x_q, x_d;
    logic [15:0]      y_q, y_d;
    pattern_e         pat_q, pat_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             en_q;
    logic             beat_acc;
    logic             frame_done;
    logic             vld_d;
    pixel_t           pix_d;

    assign beat_acc = m_axis.tvalid & m_axis.tready;
    assign busy     = (state_q != IDLE);

    // Enable is sampled one cycle before it can start a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= enable;
        end
    end

    // FSM, position counters, latched pattern and gap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            pat_q   <= PAT_SOLID;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pat_q   <= pat_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state and counter advance; pattern_sel is only captured when a frame is about to start.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        pat_d      = pat_q;
        gap_d      = gap_q;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_q) begin
                    state_d = ACTIVE;
                    pat_d   = pattern_e'(pattern_sel);
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ACTIVE: begin
                if (beat_acc) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d        = '0;
                            frame_done = 1'b1;
                            if (GAP_CYCLES > 0) begin
                                state_d = GAP;
                                gap_d   = '0;
                            end else if (en_q) begin
                                pat_d = pattern_e'(pattern_sel);
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            y_d = y_q + 16'd1;
                        end
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_END) begin
                    gap_d = '0;
                    if (en_q) begin
                        state_d = ACTIVE;
                        pat_d   = pattern_e'(pattern_sel);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pixel for the position the stream will present next cycle, so the registered beat has no extra latency.
    pattern_pixel_gen #(
        .LINE_PIXELS (LINE_PIXELS)
    ) u_pixel_gen (
        .pattern (pat_d),
        .x       (x_d),
        .y       (y_d),
        .pixel   (pix_d)
    );

    assign vld_d = (state_d == ACTIVE);

    // Registered stream outputs; all zero whenever no beat is offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tuser  <= 1'b0;
            m_axis.tlast  <= 1'b0;
        end else begin
            m_axis.tvalid <= vld_d;
            m_axis.tdata  <= vld_d ? pix_d : '0;
            m_axis.tuser  <= vld_d && (x_d == 16'd0) && (y_d == 16'd0);
            m_axis.tlast  <= vld_d && (x_d == X_LAST) && (y_d == Y_LAST);
        end
    end

    // Completed-frame counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if (frame_done) begin
            frame_count <= frame_count + 32'd1;
        end
    end

`ifdef PATTERN_SRC_FRAME_XOR_EN
    logic [31:0] xor_acc_q;
    logic [31:0] xor_acc_d;

    // SOF beat restarts the running XOR so a frame's signature never includes the previous frame.
    assign xor_acc_d = m_axis.tuser ? {8'd0, m_axis.tdata}
                                    : (xor_acc_q ^ {8'd0, m_axis.tdata});

    // Running XOR per accepted beat; published on the accepted EOF beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_acc_q <= '0;
            frame_xor <= '0;
        end else if (beat_acc) begin
            xor_acc_q <= xor_acc_d;
            if (m_axis.tlast) begin
                frame_xor <= xor_acc_d;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_stream_pattern_source.sv
// Directed bench for the pattern source: reset, latency, ramp/bars frames, stalls, enable drop, mid-frame reset.
// Latency: n/a.
// Backpressure: tready driven from a fixed toggle pattern in the stall frame.
module tb_axi_stream_pattern_source;
    import pattern_src_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en_a, en_b;
    logic [1:0]  sel_a, sel_b;
    logic [31:0] fc_a, fc_b;
    logic        busy_a, busy_b;

    int errors = 0;
    int checks = 0;

    axi_stream_pattern_source_if axis_a ();
    axi_stream_pattern_source_if axis_b ();

`ifdef PATTERN_SRC_FRAME_XOR_EN
    logic [31:0] fx_a, fx_b, fx_c, fc_c;
    logic        en_c, busy_c;
    logic [1:0]  sel_c;
    axi_stream_pattern_source_if axis_c ();
`endif

    axi_stream_pattern_source #(.LINE_PIXELS(8), .FRAME_LINES(2), .GAP_CYCLES(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .pattern_sel(sel_a), .m_axis(axis_a),
        .frame_count(fc_a), .busy(busy_a)
`ifdef PATTERN_SRC_FRAME_XOR_EN
        , .frame_xor(fx_a)
`endif
    );

    axi_stream_pattern_source #(.LINE_PIXELS(16), .FRAME_LINES(2), .GAP_CYCLES(0)) u_bar (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .pattern_sel(sel_b), .m_axis(axis_b),
        .frame_count(fc_b), .busy(busy_b)
`ifdef PATTERN_SRC_FRAME_XOR_EN
        , .frame_xor(fx_b)
`endif
    );

`ifdef PATTERN_SRC_FRAME_XOR_EN
    axi_stream_pattern_source #(.LINE_PIXELS(9), .FRAME_LINES(9), .GAP_CYCLES(3)) u_xor (
        .clk(clk), .rst_n(rst_n), .enable(en_c), .pattern_sel(sel_c), .m_axis(axis_c),
        .frame_count(fc_c), .busy(busy_c), .frame_xor(fx_c)
    );
`endif

    // Hand-derived colours for BARS on a 16-pixel line: bar = x/2.
    logic [23:0] bars16 [16] = '{24'h000000, 24'h000000, 24'h0000FF, 24'h0000FF,
                                 24'h00FF00, 24'h00FF00, 24'h00FFFF, 24'h00FFFF,
                                 24'hFF0000, 24'hFF0000, 24'hFF00FF, 24'hFF00FF,
                                 24'hFFFF00, 24'hFFFF00, 24'hFFFFFF, 24'hFFFFFF};

    logic [15:0] rdy_pat = 16'hA6B2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model_pix(input logic [1:0] p, input int x, input int y, input int lp);
        logic [7:0] xb;
        int b;
        xb = x[7:0];
        case (p)
            2'd0: return 24'hFFFFFF;
            2'd1: return {xb, xb, xb};
            2'd2: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: begin
                b = (x * 8) / lp;
                if (b > 7) b = 7;
                return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
            end
        endcase
    endfunction

    // Follow one 8x2 frame on u_dut: every offered beat must match the model for the next unaccepted position.
    task automatic run_frame_a(input logic [1:0] pat, input bit toggle, input int drop_at,
                               input int stop_at, input string tag, output int first_cyc);
        int n;
        int cyc;
        logic [31:0] exp;
        n = 0;
        cyc = 0;
        first_cyc = -1;
        while (n < 16) begin
            @(negedge clk);
            cyc++;
            if (cyc > 400) begin
                chk({tag, "_timeout"}, n, 16);
                return;
            end
            if (n == drop_at) begin
                en_a  = 1'b0;
                sel_a = 2'd0;
            end
            if (axis_a.tvalid) begin
                if (first_cyc < 0) first_cyc = cyc;
                exp = {6'd0, (n == 0), (n == 15), model_pix(pat, n % 8, n / 8, 8)};
                chk($sformatf("%s_beat%0d", tag, n),
                    {6'd0, axis_a.tuser, axis_a.tlast, axis_a.tdata}, exp);
                if (n == stop_at) return;
                axis_a.tready = toggle ? rdy_pat[cyc[3:0]] : 1'b1;
                if (axis_a.tready) n++;
            end
        end
    endtask

    initial begin : stim
        int fc1;
        logic [31:0] xm;
        rst_n = 1'b0;
        en_a = 1'b0; sel_a = 2'd0; axis_a.tready = 1'b0;
        en_b = 1'b0; sel_b = 2'd0; axis_b.tready = 1'b0;
`ifdef PATTERN_SRC_FRAME_XOR_EN
        en_c = 1'b0; sel_c = 2'd0; axis_c.tready = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 32'(axis_a.tvalid), 0);
        chk("rst_tdata",  32'(axis_a.tdata),  0);
        chk("rst_tuser",  32'(axis_a.tuser),  0);
        chk("rst_tlast",  32'(axis_a.tlast),  0);
        chk("rst_fc",     fc_a,               0);
        chk("rst_busy",   32'(busy_a),        0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_enable_tvalid", 32'(axis_a.tvalid), 0);

        // Frame 1: HRAMP, free-flowing; first beat two cycles after enable.
        en_a = 1'b1; sel_a = 2'd1; axis_a.tready = 1'b1;
        run_frame_a(2'd1, 1'b0, -1, -1, "f1", fc1);
        chk("f1_latency", fc1, 2);
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            chk($sformatf("f1_gap%0d_tvalid", g), 32'(axis_a.tvalid), 0);
            if (g == 0) chk("f1_frame_count", fc_a, 1);
        end
`ifdef PATTERN_SRC_FRAME_XOR_EN
        chk("f1_frame_xor", fx_a, 32'h00000000);
`endif

        // Frame 2: same pattern under toggling backpressure; first beat right after the 3-cycle gap.
        run_frame_a(2'd1, 1'b1, -1, -1, "f2", fc1);
        chk("f2_gap_len", fc1, 1);
        axis_a.tready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            chk($sformatf("f2_gap%0d_tvalid", g), 32'(axis_a.tvalid), 0);
            if (g == 0) chk("f2_frame_count", fc_a, 2);
        end

        // Frame 3: enable dropped and select changed at beat 5; frame still completes as HRAMP.
        run_frame_a(2'd1, 1'b0, 5, -1, "f3", fc1);
        chk("f3_gap_len", fc1, 1);
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            chk($sformatf("f3_gap%0d_busy", g), {31'd0, busy_a} | {31'd0, axis_a.tvalid} << 1, 1);
        end
        @(negedge clk);
        chk("f3_idle_busy",  32'(busy_a), 0);
        chk("f3_idle_fc",    fc_a, 3);
        @(negedge clk);
        chk("f3_idle_tvalid", 32'(axis_a.tvalid), 0);

        // Frame 4: BARS on 8 pixels, reset asserted while beat 9 is offered.
        en_a = 1'b1; sel_a = 2'd3;
        run_frame_a(2'd3, 1'b0, -1, 9, "f4", fc1);
        chk("f4_latency", fc1, 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", 32'(axis_a.tvalid), 0);
        chk("midrst_tdata",  32'(axis_a.tdata),  0);
        chk("midrst_tuser",  32'(axis_a.tuser),  0);
        chk("midrst_tlast",  32'(axis_a.tlast),  0);
        chk("midrst_busy",   32'(busy_a),        0);
        chk("midrst_fc",     fc_a,               0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame_a(2'd3, 1'b0, -1, -1, "f5", fc1);
        chk("f5_latency", fc1, 2);
        @(negedge clk);
        chk("f5_frame_count", fc_a, 1);
        en_a = 1'b0;

        // 16-pixel BARS, zero gap: second frame's SOF follows the EOF beat immediately.
        en_b = 1'b1; sel_b = 2'd3; axis_b.tready = 1'b1;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 32; n++) begin
            chk($sformatf("bar16_beat%0d", n),
                {5'd0, axis_b.tvalid, axis_b.tuser, axis_b.tlast, axis_b.tdata},
                {5'd0, 1'b1, (n == 0), (n == 31), bars16[n % 16]});
            @(negedge clk);
        end
        chk("bar16_b2b_sof", {30'd0, axis_b.tvalid, axis_b.tuser}, 3);
        chk("bar16_frame_count", fc_b, 1);
        en_b = 1'b0; axis_b.tready = 1'b0;

`ifdef PATTERN_SRC_FRAME_XOR_EN
        // 9x9 frames: CHECKER then HRAMP, signatures against the bench XOR model.
        en_c = 1'b1; sel_c = 2'd2; axis_c.tready = 1'b1;
        repeat (5) @(negedge clk);
        sel_c = 2'd1;
        for (int c = 0; c < 400 && fc_c != 1; c++) @(negedge clk);
        chk("xor_wait_f1", fc_c, 1);
        xm = 0;
        for (int y = 0; y < 9; y++)
            for (int x = 0; x < 9; x++) xm = xm ^ {8'd0, model_pix(2'd2, x, y, 9)};
        chk("xor_checker9", fx_c, xm);
        for (int c = 0; c < 400 && fc_c != 2; c++) @(negedge clk);
        chk("xor_wait_f2", fc_c, 2);
        xm = 0;
        for (int y = 0; y < 9; y++)
            for (int x = 0; x < 9; x++) xm = xm ^ {8'd0, model_pix(2'd1, x, y, 9)};
        chk("xor_hramp9", fx_c, xm);
        en_c = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_stream_pattern_source.md
AXI_STREAM_PATTERN_SOURCE -- requirements
Module: axi_stream_pattern_source

Interface
REQ-001 LINE_PIXELS, default 480, pixels per line (range 8..65535).
REQ-002 FRAME_LINES, default 272, lines per frame (range 1..65535).
REQ-003 GAP_CYCLES, default 16, idle cycles between frames (0 allowed).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  run request; frames start only while high.
REQ-007 pattern_sel  input  2  pattern for next frame.
REQ-008 m_axis_tdata  output  24  pixel {R[23:16],G[15:8],B[7:0]}.
REQ-009 m_axis_tvalid  output  1  beat valid.
REQ-010 m_axis_tlast  output  1  last pixel of frame.
REQ-011 m_axis_tuser  output  1  first pixel of frame (SOF).
REQ-012 m_axis_tready  input  1  downstream accept.
REQ-013 frame_count  output  32  completed frames, wraps 0xFFFFFFFF->0.
REQ-014 busy  output  1  high in ACTIVE or GAP.

Function
REQ-015 FSM states IDLE, ACTIVE, GAP.
REQ-016 IDLE->ACTIVE on the cycle after enable sampled high; pattern_sel latched on that transition, held for the whole frame.
REQ-017 ACTIVE: tvalid=1; pixel counter x (0..LINE_PIXELS-1), line counter y (0..FRAME_LINES-1) advance only on tvalid&&tready.
REQ-018 x wraps to 0 and y increments on accepted beat with x==LINE_PIXELS-1.
REQ-019 tuser=1 only while x==0,y==0; tlast=1 only while x==LINE_PIXELS-1,y==FRAME_LINES-1.
REQ-020 While tvalid&&!tready, tdata/tlast/tuser SHALL hold stable; no beat dropped or duplicated.
REQ-021 Accepted tlast beat: frame_count+1, x,y<=0, ->GAP if GAP_CYCLES>0 else direct to next-state decision.
REQ-022 GAP: tvalid=0 for exactly GAP_CYCLES cycles; then ->ACTIVE if enable high (re-latch pattern_sel) else ->IDLE.
REQ-023 enable deassert mid-frame SHALL NOT truncate: current frame completes, then GAP, then IDLE.
REQ-024 Patterns: 0 SOLID=24'hFFFFFF; 1 HRAMP={3{x[7:0]}}; 2 CHECKER=(x[3]^y[3])?24'hFFFFFF:24'h000000; 3 BARS, b=(x*8)/LINE_PIXELS clipped to 7, each channel 8'hFF if its bit set (R=b[2],G=b[1],B=b[0]) else 8'h00.
REQ-025 tdata is a registered function of latched pattern, x, y; zero added latency vs. x/y beat position (pixel for beat n is presented with beat n).
REQ-026 tdata=0, tlast=0, tuser=0 whenever tvalid=0.

Reset
REQ-027 rst_n low: state IDLE, x=y=0, tvalid/tlast/tuser=0, tdata=0, frame_count=0, busy=0, latched pattern=0, gap counter=0, immediately including mid-frame.
REQ-028 First frame after reset release requires enable high; earliest tvalid is 2 cycles after first enable-high edge sampled.

Configuration
REQ-029 Macro PATTERN_SRC_FRAME_XOR_EN: when defined, add output frame_xor[31:0] = XOR of {8'd0,tdata} over all accepted beats of the last completed frame, updated on accepted tlast beat, reset 0; running accumulator cleared at SOF beat.
REQ-030 Without PATTERN_SRC_FRAME_XOR_EN the port and accumulator SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package pattern_src_pkg holds pattern enum (PAT_SOLID=0, PAT_HRAMP=1, PAT_CHECKER=2, PAT_BARS=3), FSM state enum, PIXEL_W=24.
REQ-032 Pixel colour function is a sub-module pattern_pixel_gen (inputs pattern, x, y; output 24-bit pixel, combinational).

Verification (LINE_PIXELS=8, FRAME_LINES=2, GAP_CYCLES=3 unless stated)
REQ-033 tready=1, enable=1, sel=1 -> 16 beats, tdata 000000,010101..070707 twice, tuser on beat 0, tlast on beat 15, 3 idle cycles, frame_count=1.
REQ-034 tready toggled 1010 pseudo-random -> identical beat sequence to REQ-033, tdata stable during every stall.
REQ-035 sel=3, LINE_PIXELS=16 -> beat x=0..15 colours 000000,000000,0000FF,0000FF,00FF00,...,FFFFFF,FFFFFF.
REQ-036 enable dropped at beat 5, sel changed to 0 mid-frame -> frame finishes with sel=1 data, GAP, IDLE, busy=0, frame_count=1.
REQ-037 rst_n low at beat 9 -> all outputs 0 same cycle; after release and enable, next frame starts with tuser, frame_count counts from 0.
REQ-038 PATTERN_SRC_FRAME_XOR_EN, sel=0, 16 beats -> frame_xor=0x00000000; sel=1 -> 0x00000000; sel=2 (FRAME_LINES=9, LINE_PIXELS=9) -> matches bench XOR model.
